// File: rtl/kyber_reduction_pipe.sv
// Three-stage valid/ready Barrett reduction pipe: result_o = x_i mod Q, fully reduced.
// Optional per-sample range flag (x_i >= Q*Q) on err_o when KRED_RANGE_CHK_EN is defined.
module kyber_reduction_pipe #(
   parameter int unsigned Q      = 3329,
   parameter int unsigned Q_W    = $clog2(Q),
   parameter int unsigned DATA_W = 2*Q_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] x_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [Q_W-1:0]    result_o,
`ifdef KRED_RANGE_CHK_EN
   output logic              err_o,
`endif
   output logic              busy_o
);

   localparam int unsigned     K      = 2*Q_W;
   localparam int unsigned     MU_W   = Q_W + 2;
   localparam int unsigned     QH_W   = Q_W + 1;
   localparam int unsigned     PROD_W = DATA_W + MU_W;
   localparam longint unsigned MU_L   = (64'd1 << K) / 64'(Q);
   localparam logic [MU_W-1:0]   MU   = MU_W'(MU_L);
   localparam logic [DATA_W-1:0] Q_D  = DATA_W'(Q);
   localparam logic [DATA_W-1:0] Q2_D = DATA_W'(2*Q);

   logic              en;
   logic              s1_v, s2_v, s3_v;
   logic [DATA_W-1:0] s1_x;
   logic [QH_W-1:0]   s1_qh;
   logic [DATA_W-1:0] s2_r;
   logic [QH_W-1:0]   q_hat_c;
   logic [DATA_W-1:0] r_c;
   logic [Q_W-1:0]    red_c;

   // One global advance: the whole pipe stalls only when the output is held
   assign en          = !s3_v || out_ready_i;
   assign in_ready_o  = en;
   assign out_valid_o = s3_v;
   assign busy_o      = s1_v | s2_v | s3_v;

   // Quotient estimate never exceeds the true quotient, so r_c below is non-negative and < 3Q
   assign q_hat_c = QH_W'((PROD_W'(x_i) * PROD_W'(MU)) >> K);
   assign r_c     = s1_x - DATA_W'(s1_qh) * Q_D;

   always_comb begin
      red_c = Q_W'(s2_r);
      if (s2_r >= Q2_D) begin
         red_c = Q_W'(s2_r - Q2_D);
      end else if (s2_r >= Q_D) begin
         red_c = Q_W'(s2_r - Q_D);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_v     <= 1'b0;
         s2_v     <= 1'b0;
         s3_v     <= 1'b0;
         s1_x     <= '0;
         s1_qh    <= '0;
         s2_r     <= '0;
         result_o <= '0;
      end else if (en) begin
         s1_v     <= in_valid_i;
         s2_v     <= s1_v;
         s3_v     <= s2_v;
         s1_x     <= x_i;
         s1_qh    <= q_hat_c;
         s2_r     <= r_c;
         result_o <= red_c;
      end
   end

`ifdef KRED_RANGE_CHK_EN
   localparam logic [DATA_W-1:0] Q_SQ = DATA_W'(64'(Q) * 64'(Q));

   logic s1_err, s2_err;

   // Flag is qualified by valid so bubbles never carry a stale error
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s1_err <= 1'b0;
         s2_err <= 1'b0;
         err_o  <= 1'b0;
      end else if (en) begin
         s1_err <= in_valid_i && (x_i >= Q_SQ);
         s2_err <= s1_v && s1_err;
         err_o  <= s2_v && s2_err;
      end
   end
`endif

endmodule

// File: tb/tb_kyber_reduction_pipe.sv
// Scoreboard bench for kyber_reduction_pipe: random and directed operands against x mod Q.
module tb_kyber_reduction_pipe;

   localparam int unsigned Q      = 3329;
   localparam int unsigned Q_W    = 12;
   localparam int unsigned DATA_W = 24;

   typedef struct {
      int unsigned res;
      bit          err;
      int          cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] x = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic [Q_W-1:0]    result;
   logic              busy;
`ifdef KRED_RANGE_CHK_EN
   logic              err;
`endif

   int   n_vec = 0;
   int   n_err = 0;
   int   cyc = 0;
   bit   lat_chk = 1'b0;
   bit   held = 1'b0;
   int unsigned held_res = 0;
   bit   done = 1'b0;
   exp_t q[$];

   kyber_reduction_pipe #(.Q(Q)) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .x_i        (x),
      .out_valid_o(out_valid),
      .out_ready_i(out_ready),
      .result_o   (result),
`ifdef KRED_RANGE_CHK_EN
      .err_o      (err),
`endif
      .busy_o     (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint act, input longint expv);
      n_vec++;
      if (act != expv) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, expv, $time);
      end
   endtask

   // Reference model: plain modular arithmetic on the integer operand
   function automatic exp_t model(input logic [DATA_W-1:0] xv, input int c);
      exp_t e;
      longint unsigned xl;
      xl    = 64'(xv);
      e.res = int'(xl % 64'(Q));
      e.err = (xl >= 64'(Q) * 64'(Q));
      e.cyc = c;
      return e;
   endfunction

   // Monitor: handshake rule, output hold, scoreboard pop, accept push
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         held = 1'b0;
      end else begin
         check("in_ready_rule", in_ready, (!out_valid || out_ready));
         if (held) begin
            check("hold_valid", out_valid, 1);
            check("hold_result", result, held_res);
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_output", 1, 0);
            end else begin
               e = q.pop_front();
               check("result", result, e.res);
`ifdef KRED_RANGE_CHK_EN
               check("err", err, e.err);
`endif
               if (lat_chk) check("latency", cyc - e.cyc, 3);
            end
         end
         held     = out_valid && !out_ready;
         held_res = result;
         if (in_valid && in_ready) q.push_back(model(x, cyc));
      end
   end

   task automatic send(input logic [DATA_W-1:0] v);
      bit ok;
      ok       = 1'b0;
      in_valid = 1'b1;
      x        = v;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_empty", q.size(), 0);
   endtask

   initial begin
      logic [DATA_W-1:0] dir [6];
      logic [DATA_W-1:0] v;
      dir = '{24'd0, 24'd3328, 24'd3329, 24'd6658, 24'd12345, 24'd11082240};

      // T1: reset and idle
      repeat (3) @(posedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle_out_valid", out_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_result", result, 0);
      check("idle_in_ready", in_ready, 1);
`ifdef KRED_RANGE_CHK_EN
      check("idle_err", err, 0);
`endif
      @(posedge clk);
      #1;

      // T2: directed values back-to-back
      lat_chk = 1'b1;
      foreach (dir[i]) send(dir[i]);
      idle(6);
      drain();

      // T4: bubble between two samples
      send(24'd4000);
      idle(1);
      send(24'd7000);
      idle(6);
      drain();

      // T6: range boundary around Q*Q
      send(24'd11082241);
      send(24'd11082240);
      send(24'hFFFFFF);
      idle(6);
      drain();
      lat_chk = 1'b0;

      // T3: backpressure mid-stream
      fork
         for (int i = 0; i < 8; i++) send(DATA_W'(1000 * i + 77));
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      idle(6);
      drain();

      // T5: reset with three samples in flight
      send(24'd5000);
      send(24'd6000);
      send(24'd7000);
      #1 rst_n = 1'b0;
      #1;
      check("midrst_out_valid", out_valid, 0);
      check("midrst_busy", busy, 0);
      check("midrst_result", result, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle(10);
      check("post_rst_busy", busy, 0);

      // Random stream with random consumer stalls
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 400; i++) begin
               case ($urandom_range(3))
                  0: v = DATA_W'($urandom_range(0, 3328 * 3) );
                  1: v = DATA_W'(Q * $urandom_range(0, 5039) - $urandom_range(0, 1));
                  default: v = DATA_W'($urandom);
               endcase
               if ($urandom_range(3) == 0) idle(1);
               send(v);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
